// File: rtl/sprite_rom_pkg.sv
// Shared defaults, sprite index constants and the response-buffer entry type
// for the sprite ROM reader.
package sprite_rom_pkg;
  localparam int DEF_NUM_SPRITES      = 7;
  localparam int DEF_NUM_BANKS        = 2;
  localparam int DEF_WORDS_PER_SPRITE = 1024;
  localparam int DEF_WORD_W           = 16;
  localparam int DEF_FIFO_DEPTH       = 4;

  localparam int DEF_SPRITE_W = $clog2(DEF_NUM_SPRITES);
  localparam int DEF_ADDR_W   = $clog2(DEF_WORDS_PER_SPRITE);
  localparam logic [DEF_SPRITE_W-1:0] SPRITE_LAST = DEF_SPRITE_W'(DEF_NUM_SPRITES - 1);

  typedef struct packed {
    logic [DEF_WORD_W-1:0] data;
    logic                  err;
    logic                  last;
  } rsp_entry_t;

  // Bank image key: bank b word p reads back as key(b) ^ p.
  function automatic logic [DEF_WORD_W-1:0] bank_key(int b);
    return DEF_WORD_W'(32'hC000 + (b << 12));
  endfunction
endpackage

// File: rtl/sprite_rom_reader_if.sv
// Request/response bus between a sprite fetch client and sprite_rom_reader.
interface sprite_rom_reader_if
  import sprite_rom_pkg::*;
#(
  parameter int SPRITE_W = DEF_SPRITE_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int WORD_W   = DEF_WORD_W
);
  logic                req_valid_i;
  logic                req_ready_o;
  logic [SPRITE_W-1:0] req_sprite_i;
  logic [ADDR_W-1:0]   req_addr_i;
  logic [7:0]          req_len_i;
  logic                rsp_valid_o;
  logic                rsp_ready_i;
  logic [WORD_W-1:0]   rsp_data_o;
  logic                rsp_err_o;
  logic                rsp_last_o;

  modport slave (
    input  req_valid_i, req_sprite_i, req_addr_i, req_len_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o, rsp_last_o
  );
  modport master (
    output req_valid_i, req_sprite_i, req_addr_i, req_len_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o, rsp_last_o
  );
endinterface

// File: rtl/sprite_rom_bank.sv
// One sprite ROM bank: 1-cycle synchronous read, output holds when not enabled.
// Contents are a closed-form image selected per bank by INIT_KEY.
module sprite_rom_bank #(
  parameter int                PADDR_W  = 12,
  parameter int                WORD_W   = 16,
  parameter logic [WORD_W-1:0] INIT_KEY = '0
) (
  input  logic               clk,
  input  logic               en_i,
  input  logic [PADDR_W-1:0] addr_i,
  output logic [WORD_W-1:0]  data_o
);
  logic [WORD_W-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (en_i) data_d = INIT_KEY ^ WORD_W'(addr_i);
  end

  always_ff @(posedge clk) data_q <= data_d;

  assign data_o = data_q;
endmodule

// File: rtl/sprite_rom_reader.sv
// Burst reader over banked sprite ROMs: credit-limited issue, 1-cycle ROM read,
// sideband pipelined alongside, in-order response FIFO.
module sprite_rom_reader
  import sprite_rom_pkg::*;
#(
  parameter int NUM_SPRITES      = DEF_NUM_SPRITES,
  parameter int NUM_BANKS        = DEF_NUM_BANKS,
  parameter int WORDS_PER_SPRITE = DEF_WORDS_PER_SPRITE,
  parameter int WORD_W           = DEF_WORD_W,
  parameter int FIFO_DEPTH       = DEF_FIFO_DEPTH
) (
  input  logic               clk,
  input  logic               rst_ni,
  sprite_rom_reader_if.slave bus,
  output logic               busy_o
);
  localparam int SPRITE_W = $clog2(NUM_SPRITES);
  localparam int ADDR_W   = $clog2(WORDS_PER_SPRITE);
  localparam int BANK_W   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int SLOTS    = (NUM_SPRITES + NUM_BANKS - 1) / NUM_BANKS;
  localparam int PADDR_W  = $clog2(SLOTS * WORDS_PER_SPRITE);
  localparam int PTR_W    = $clog2(FIFO_DEPTH);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_BURST = 1'b1;

  logic [0:0]          state_q, state_d;
  logic [SPRITE_W-1:0] sprite_q, sprite_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          rem_q, rem_d;
  logic [PTR_W:0]      out_cnt_q, out_cnt_d;

  logic                s1_vld_q, s1_vld_d;
  logic [BANK_W-1:0]   s1_bank_q, s1_bank_d;
  logic                s1_err_q, s1_err_d;
  logic                s1_last_q, s1_last_d;

  rsp_entry_t          mem_q [FIFO_DEPTH];
  rsp_entry_t          mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]      fifo_cnt_q, fifo_cnt_d;

  logic                idle, credit, req_ready, accept, issue, pop, rsp_valid;
  logic [SPRITE_W-1:0] iss_sprite;
  logic [ADDR_W-1:0]   iss_addr;
  logic                iss_last, iss_err;
  logic [BANK_W-1:0]   iss_bank;
  logic [PADDR_W-1:0]  iss_paddr;
  logic [NUM_BANKS-1:0]             bank_en;
  logic [NUM_BANKS-1:0][WORD_W-1:0] bank_rd;
  rsp_entry_t          wr_entry, head;

  // Credit covers words in the ROM stage plus words buffered, so a write never
  // finds the FIFO full; it is registered, keeping rsp_ready_i off req_ready_o.
  always_comb begin
    idle       = (state_q == S_IDLE);
    credit     = 32'(out_cnt_q) < FIFO_DEPTH;
    req_ready  = rst_ni && idle && credit;
    accept     = req_ready && bus.req_valid_i;
    issue      = accept || (!idle && credit);
    iss_sprite = idle ? bus.req_sprite_i : sprite_q;
    iss_addr   = idle ? bus.req_addr_i : addr_q;
    iss_last   = idle ? (bus.req_len_i == 8'd0) : (rem_q == 8'd1);
    iss_err    = 32'(iss_sprite) >= NUM_SPRITES;
    iss_bank   = BANK_W'(32'(iss_sprite) % NUM_BANKS);
    iss_paddr  = PADDR_W'((32'(iss_sprite) / NUM_BANKS) * WORDS_PER_SPRITE + 32'(iss_addr));
    for (int b = 0; b < NUM_BANKS; b++)
      bank_en[b] = issue && !iss_err && (32'(iss_bank) == b);

    state_d  = state_q;
    sprite_d = sprite_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    if (accept) begin
      sprite_d = bus.req_sprite_i;
      addr_d   = bus.req_addr_i + ADDR_W'(1);
      rem_d    = bus.req_len_i;
      if (bus.req_len_i != 8'd0) state_d = S_BURST;
    end else if (!idle && credit) begin
      addr_d = addr_q + ADDR_W'(1);
      rem_d  = rem_q - 8'd1;
      if (rem_q == 8'd1) state_d = S_IDLE;
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    sprite_rom_bank #(
      .PADDR_W (PADDR_W),
      .WORD_W  (WORD_W),
      .INIT_KEY(WORD_W'(bank_key(b)))
    ) u_bank (
      .clk   (clk),
      .en_i  (bank_en[b]),
      .addr_i(iss_paddr),
      .data_o(bank_rd[b])
    );
  end

  always_comb begin
    s1_vld_d  = issue;
    s1_bank_d = iss_bank;
    s1_err_d  = iss_err;
    s1_last_d = iss_last;

    wr_entry.data = s1_err_q ? '0 : DEF_WORD_W'(bank_rd[s1_bank_q]);
    wr_entry.err  = s1_err_q;
    wr_entry.last = s1_last_q;

    head      = mem_q[rd_ptr_q];
    rsp_valid = rst_ni && (fifo_cnt_q != '0);
    pop       = rsp_valid && bus.rsp_ready_i;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (s1_vld_q) begin
      mem_d[wr_ptr_q] = wr_entry;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);

    fifo_cnt_d = fifo_cnt_q;
    case ({s1_vld_q, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
    out_cnt_d = out_cnt_q;
    case ({issue, pop})
      2'b10:   out_cnt_d = out_cnt_q + 1'b1;
      2'b01:   out_cnt_d = out_cnt_q - 1'b1;
      default: out_cnt_d = out_cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      sprite_q   <= '0;
      addr_q     <= '0;
      rem_q      <= '0;
      out_cnt_q  <= '0;
      s1_vld_q   <= 1'b0;
      s1_bank_q  <= '0;
      s1_err_q   <= 1'b0;
      s1_last_q  <= 1'b0;
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      sprite_q   <= sprite_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      out_cnt_q  <= out_cnt_d;
      s1_vld_q   <= s1_vld_d;
      s1_bank_q  <= s1_bank_d;
      s1_err_q   <= s1_err_d;
      s1_last_q  <= s1_last_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  // Outputs read zero whenever nothing is presented, including under reset.
  assign bus.req_ready_o = req_ready;
  assign bus.rsp_valid_o = rsp_valid;
  assign bus.rsp_data_o  = rsp_valid ? WORD_W'(head.data) : '0;
  assign bus.rsp_err_o   = rsp_valid && head.err;
  assign bus.rsp_last_o  = rsp_valid && head.last;
  assign busy_o          = rst_ni && ((state_q == S_BURST) || (out_cnt_q != '0));
endmodule
